// File: rtl/calc_entry_if.sv
// Bundle between the keypad/ALU side (master) and the calculator entry controller (slave).
interface calc_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_err;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        busy;
  logic [15:0] disp_value;
  logic        err;

  modport master (
    output key_valid, key_code, alu_done, alu_result, alu_err,
    input  alu_start, alu_op, alu_a, alu_b, busy, disp_value, err
  );

  modport slave (
    input  key_valid, key_code, alu_done, alu_result, alu_err,
    output alu_start, alu_op, alu_a, alu_b, busy, disp_value, err
  );
endinterface

// File: rtl/calc_entry_ctrl.sv
// Calculator key sequencer: builds two decimal operands and an operator from keypad events,
// runs the external ALU via start/done, and handles chaining, clear, error and timeout.
module calc_entry_ctrl #(
  parameter int unsigned Digits     = 4,
  parameter int unsigned AluTimeout = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  calc_entry_if.slave      bus_io
);

  localparam int unsigned CntW = $clog2(Digits + 1);
  localparam int unsigned TmoW = $clog2(AluTimeout);

  typedef enum logic [2:0] {
    StEnterA,
    StEnterB,
    StWaitAlu,
    StShowResult,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       a_q, a_d, b_q, b_d, disp_q, disp_d;
  logic [1:0]        op_q, op_d;
  logic [CntW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              start_q, start_d, busy_q, busy_d, err_q, err_d;

  logic        is_digit, is_op, is_hash, is_star;
  logic [1:0]  key_op;

  always_comb begin
    is_digit = bus_io.key_valid && (bus_io.key_code < 4'd10);
    is_op    = bus_io.key_valid && (bus_io.key_code >= 4'd10) && (bus_io.key_code <= 4'd13);
    is_hash  = bus_io.key_valid && (bus_io.key_code == 4'd14);
    is_star  = bus_io.key_valid && (bus_io.key_code == 4'd15);
    key_op   = 2'(bus_io.key_code - 4'd10);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    tmo_d   = tmo_q;
    start_d = 1'b0;

    // Clear works everywhere except while the ALU owns the operands.
    if (is_star && (state_q != StWaitAlu)) begin
      state_d = StEnterA;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else begin
      unique case (state_q)
        StEnterA: begin
          if (is_digit && (cnt_a_q < CntW'(Digits))) begin
            a_d     = a_q * 16'd10 + 16'(bus_io.key_code);
            cnt_a_d = cnt_a_q + CntW'(1);
          end else if (is_op) begin
            op_d    = key_op;
            b_d     = '0;
            cnt_b_d = '0;
            state_d = StEnterB;
          end
        end
        StEnterB: begin
          if (is_digit && (cnt_b_q < CntW'(Digits))) begin
            b_d     = b_q * 16'd10 + 16'(bus_io.key_code);
            cnt_b_d = cnt_b_q + CntW'(1);
          end else if (is_op) begin
            op_d = key_op;
          end else if (is_hash && (cnt_b_q != '0)) begin
            tmo_d   = '0;
            start_d = 1'b1;
            state_d = StWaitAlu;
          end
        end
        StWaitAlu: begin
          tmo_d = tmo_q + TmoW'(1);
          if (bus_io.alu_done) begin
            if (bus_io.alu_err) begin
              state_d = StError;
            end else begin
              a_d     = bus_io.alu_result;
              cnt_a_d = CntW'(Digits);
              state_d = StShowResult;
            end
          end else if (tmo_q == TmoW'(AluTimeout - 1)) begin
            state_d = StError;
          end
        end
        StShowResult: begin
          if (is_digit) begin
            a_d     = 16'(bus_io.key_code);
            cnt_a_d = CntW'(1);
            state_d = StEnterA;
          end else if (is_op) begin
            op_d    = key_op;
            b_d     = '0;
            cnt_b_d = '0;
            state_d = StEnterB;
          end
        end
        StError: ;
        default: state_d = StEnterA;
      endcase
    end

    busy_d = (state_d == StWaitAlu);
    err_d  = (state_d == StError);
    unique case (state_d)
      StEnterB: disp_d = (cnt_b_d != '0) ? b_d : a_d;
      StError:  disp_d = 16'hFFFF;
      default:  disp_d = a_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEnterA;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      tmo_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      disp_q  <= disp_d;
    end
  end

  assign bus_io.alu_start  = start_q;
  assign bus_io.alu_op     = op_q;
  assign bus_io.alu_a      = a_q;
  assign bus_io.alu_b      = b_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.disp_value = disp_q;
  assign bus_io.err        = err_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: key sequences with hand-computed expected outputs.
module tb_calc_entry_ctrl;

  localparam logic [3:0] KA = 4'd10, KB = 4'd11, KD = 4'd13, KHash = 4'd14, KStar = 4'd15;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   busy_cnt;
  int   start_cnt;
  int   start_idx;
  int   err_idx;

  calc_entry_if bus ();

  calc_entry_ctrl #(
    .Digits     (4),
    .AluTimeout (1024)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive a key for one cycle; returns at the negedge where the result is visible.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  // Called right after '#' is pressed; asserts done at loop index done_at.
  task automatic run_alu(input int done_at, input logic [15:0] res, input logic e);
    busy_cnt  = 0;
    start_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.alu_start) start_cnt++;
      if (i == done_at) begin
        bus.alu_done   = 1'b1;
        bus.alu_result = res;
        bus.alu_err    = e;
      end else begin
        bus.alu_done = 1'b0;
        bus.alu_err  = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    rst_n          = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'd0;
    bus.alu_done   = 1'b0;
    bus.alu_result = 16'd0;
    bus.alu_err    = 1'b0;

    #12;
    check("rst_start", 16'(bus.alu_start), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_err", 16'(bus.err), 16'd0);
    check("rst_disp", bus.disp_value, 16'd0);
    check("rst_a", bus.alu_a, 16'd0);
    check("rst_op", 16'(bus.alu_op), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 12 + 3 = 15
    press(4'd1);
    press(4'd2);
    check("a12_disp", bus.disp_value, 16'd12);
    press(KA);
    check("opA_disp_shows_a", bus.disp_value, 16'd12);
    press(4'd3);
    check("b3_disp", bus.disp_value, 16'd3);
    press(KHash);
    check("add_start", 16'(bus.alu_start), 16'd1);
    check("add_alu_a", bus.alu_a, 16'd12);
    check("add_alu_b", bus.alu_b, 16'd3);
    check("add_alu_op", 16'(bus.alu_op), 16'd0);
    run_alu(5, 16'd15, 1'b0);
    check("add_busy_cycles", 16'(busy_cnt), 16'd6);
    check("add_start_pulses", 16'(start_cnt), 16'd1);
    check("add_result_disp", bus.disp_value, 16'd15);
    check("add_busy_low", 16'(bus.busy), 16'd0);

    // Chain: 15 - 5 = 10, then a fresh digit
    press(KB);
    check("chain_disp_a", bus.disp_value, 16'd15);
    press(4'd5);
    press(KHash);
    check("sub_alu_a", bus.alu_a, 16'd15);
    check("sub_alu_b", bus.alu_b, 16'd5);
    check("sub_alu_op", 16'(bus.alu_op), 16'd1);
    run_alu(2, 16'd10, 1'b0);
    check("sub_result_disp", bus.disp_value, 16'd10);
    press(4'd7);
    check("new_digit_disp", bus.disp_value, 16'd7);

    // Digit limit and clear
    press(KStar);
    check("clear_disp", bus.disp_value, 16'd0);
    for (int k = 1; k <= 5; k++) press(4'(k));
    check("four_digit_cap", bus.disp_value, 16'd1234);
    press(KStar);
    check("clear2_disp", bus.disp_value, 16'd0);
    check("clear2_a", bus.alu_a, 16'd0);

    // ALU error: 9 / 0
    press(4'd9);
    press(KD);
    press(4'd0);
    press(KHash);
    check("div_op", 16'(bus.alu_op), 16'd3);
    run_alu(1, 16'd0, 1'b1);
    check("alu_err_flag", 16'(bus.err), 16'd1);
    check("alu_err_disp", bus.disp_value, 16'hFFFF);
    press(4'd3);
    check("err_digit_ignored", bus.disp_value, 16'hFFFF);
    press(KStar);
    check("err_clear_flag", 16'(bus.err), 16'd0);
    check("err_clear_disp", bus.disp_value, 16'd0);

    // Timeout: no done; keys during WAIT_ALU are dropped
    press(4'd1);
    press(KA);
    press(4'd1);
    press(KHash);
    start_idx = -1;
    err_idx   = -1;
    for (int i = 0; i < 1100; i++) begin
      if (bus.alu_start && start_idx < 0) start_idx = i;
      if (bus.err && err_idx < 0) err_idx = i;
      bus.key_valid = (i == 10) || (i == 11) || (i == 12);
      bus.key_code  = (i == 11) ? KStar : ((i == 12) ? KA : 4'd5);
      @(negedge clk);
    end
    bus.key_valid = 1'b0;
    check("tmo_start_seen", 16'(start_idx), 16'd0);
    check("tmo_latency", 16'(err_idx - start_idx), 16'd1024);
    check("tmo_a_kept", bus.alu_a, 16'd1);
    check("tmo_b_kept", bus.alu_b, 16'd1);
    check("tmo_op_kept", 16'(bus.alu_op), 16'd0);
    press(KStar);
    check("tmo_clear", 16'(bus.err), 16'd0);

    // Reset while waiting on the ALU, then a late done
    press(4'd4);
    press(KA);
    press(4'd2);
    press(KHash);
    @(negedge clk);
    check("pre_rst_busy", 16'(bus.busy), 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 16'(bus.busy), 16'd0);
    check("mid_rst_a", bus.alu_a, 16'd0);
    check("mid_rst_b", bus.alu_b, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_alu(0, 16'd99, 1'b0);
    check("late_done_starts", 16'(start_cnt), 16'd0);
    check("late_done_busy", 16'(busy_cnt), 16'd0);
    check("late_done_disp", bus.disp_value, 16'd0);
    check("late_done_a", bus.alu_a, 16'd0);
    press(4'd6);
    check("post_rst_digit", bus.disp_value, 16'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
